execute_stage: RTL and testbench

// Y86-64 pipeline execute stage: ALU, condition-code (CC) register, branch/cmov condition evaluation.

---
 rtl/execute_stage.sv | 149 ++++++++++++++
 tb/tb_execute_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU operand selection, ALU, condition-code register,
// branch/cmov condition evaluation and the E->M pipeline register.
// Status vectors are one-hot: AOK=1000 HLT=0100 ADR=0010 INS=0001.
module execute_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  E_stat,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_ifun,
  input  logic [63:0] E_valC,
  input  logic [63:0] E_valA,
  input  logic [63:0] E_valB,
  input  logic [3:0]  E_dstE,
  input  logic [3:0]  E_dstM,
  input  logic        M_bubble,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  output logic [63:0] e_valE,
  output logic [3:0]  e_dstE,
  output logic        e_Cnd,
  output logic [2:0]  cc,
  output logic [3:0]  M_stat,
  output logic [3:0]  M_icode,
  output logic        M_Cnd,
  output logic [63:0] M_valE,
  output logic [63:0] M_valA,
  output logic [3:0]  M_dstE,
  output logic [3:0]  M_dstM
);

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_XOR = 2'd3;

  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic [1:0]  alufun;
  logic [63:0] alu_res;
  logic        of_new;
  logic        set_cc;
  logic        zf, sf, of;

  assign {zf, sf, of} = cc;

  // Operand selection and ALU function decode from the instruction code
  always_comb begin
    alu_a  = 64'd0;
    alu_b  = 64'd0;
    alufun = ALU_ADD;
    case (E_icode)
      I_RRMOVQ, I_OPQ:              alu_a = E_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
      I_CALL, I_PUSHQ:              alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
      I_RET, I_POPQ:                alu_a = 64'd8;
      default:                      alu_a = 64'd0;
    endcase
    case (E_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
      default:                                                   alu_b = 64'd0;
    endcase
    // Function codes above xor fall back to add
    if (E_icode == I_OPQ && E_ifun <= 4'd3) alufun = E_ifun[1:0];
  end

  // ALU: result is aluB op aluA; overflow only meaningful for add/sub
  always_comb begin
    alu_res = 64'd0;
    of_new  = 1'b0;
    case (alufun)
      ALU_SUB: begin
        alu_res = alu_b - alu_a;
        of_new  = (alu_a[63] != alu_b[63]) && (alu_res[63] != alu_b[63]);
      end
      ALU_AND: alu_res = alu_b & alu_a;
      ALU_XOR: alu_res = alu_b ^ alu_a;
      default: begin
        alu_res = alu_b + alu_a;
        of_new  = (alu_a[63] == alu_b[63]) && (alu_res[63] != alu_a[63]);
      end
    endcase
  end

  assign e_valE = alu_res;
  // Later stages reporting an exception freeze the flags
  assign set_cc = (E_icode == I_OPQ) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  // Branch/cmov condition from the flags as they stand before this edge
  always_comb begin
    e_Cnd = 1'b0;
    if (E_icode == I_RRMOVQ || E_icode == I_JXX) begin
      case (E_ifun)
        4'd0:    e_Cnd = 1'b1;
        4'd1:    e_Cnd = (sf ^ of) | zf;
        4'd2:    e_Cnd = sf ^ of;
        4'd3:    e_Cnd = zf;
        4'd4:    e_Cnd = ~zf;
        4'd5:    e_Cnd = ~(sf ^ of);
        4'd6:    e_Cnd = ~(sf ^ of) & ~zf;
        default: e_Cnd = 1'b0;
      endcase
    end
  end

  // A cmov that is not taken writes no register
  assign e_dstE = (E_icode == I_RRMOVQ && !e_Cnd) ? REG_NONE : E_dstE;

  // Condition-code register, updated only by OPq when no exception is downstream
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cc <= 3'b100;
    else if (set_cc) cc <= {(alu_res == 64'd0), alu_res[63], of_new};
  end

  // E->M pipeline register; a bubble loads the same nop image as reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst || M_bubble) begin
      M_stat  <= STAT_AOK;
      M_icode <= I_NOP;
      M_Cnd   <= 1'b0;
      M_valE  <= 64'd0;
      M_valA  <= 64'd0;
      M_dstE  <= REG_NONE;
      M_dstM  <= REG_NONE;
    end else begin
      M_stat  <= E_stat;
      M_icode <= E_icode;
      M_Cnd   <= e_Cnd;
      M_valE  <= alu_res;
      M_valA  <= E_valA;
      M_dstE  <= e_dstE;
      M_dstM  <= E_dstM;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases for the documented scenarios followed
// by randomized instructions checked against a behavioural model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic        M_bubble;
  logic [3:0]  m_stat, W_stat;
  logic [63:0] e_valE;
  logic [3:0]  e_dstE;
  logic        e_Cnd;
  logic [2:0]  cc;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;

  execute_stage dut (
    .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .M_bubble(M_bubble), .m_stat(m_stat), .W_stat(W_stat),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc(cc), .M_stat(M_stat),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  // Clock and scoreboard state
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  // Model state: the flags as the program would see them
  logic [2:0]  m_cc;
  logic [63:0] x_valE;
  logic        x_cnd, x_setcc;
  logic [3:0]  x_dstE;
  logic [2:0]  x_cc_new;
  logic [3:0]  x_stat, x_icode, x_dstMr, x_dstEr;
  logic        x_cndr;
  logic [63:0] x_valA;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: what each instruction computes, written per instruction
  task model_comb;
    logic [64:0] w;
    logic        ovf;
    logic        zf, sf, of;
    ovf = 1'b0;
    case (E_icode)
      4'h2:       x_valE = E_valA;
      4'h3:       x_valE = E_valC;
      4'h4, 4'h5: x_valE = E_valB + E_valC;
      4'h6: begin
        case (E_ifun)
          4'd1: begin
            w = {E_valB[63], E_valB} - {E_valA[63], E_valA};
            x_valE = w[63:0];
            ovf = w[64] ^ w[63];
          end
          4'd2: x_valE = E_valB & E_valA;
          4'd3: x_valE = E_valB ^ E_valA;
          default: begin
            w = {E_valB[63], E_valB} + {E_valA[63], E_valA};
            x_valE = w[63:0];
            ovf = w[64] ^ w[63];
          end
        endcase
      end
      4'h8, 4'hA: x_valE = E_valB - 64'd8;
      4'h9, 4'hB: x_valE = E_valB + 64'd8;
      default:    x_valE = 64'd0;
    endcase
    x_cc_new = {x_valE == 64'd0, x_valE[63], ovf};
    x_setcc  = (E_icode == 4'h6) && (m_stat == 4'b1000) && (W_stat == 4'b1000);
    {zf, sf, of} = m_cc;
    x_cnd = 1'b0;
    if (E_icode == 4'h2 || E_icode == 4'h7) begin
      case (E_ifun)
        4'd0: x_cnd = 1'b1;
        4'd1: x_cnd = (sf != of) || zf;
        4'd2: x_cnd = (sf != of);
        4'd3: x_cnd = zf;
        4'd4: x_cnd = !zf;
        4'd5: x_cnd = (sf == of);
        4'd6: x_cnd = (sf == of) && !zf;
        default: x_cnd = 1'b0;
      endcase
    end
    x_dstE = (E_icode == 4'h2 && !x_cnd) ? 4'hF : E_dstE;
  endtask

  // Driver: load one instruction into the E inputs
  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] de,
                       input logic [3:0] dm, input logic bub);
    E_icode = ic; E_ifun = fn; E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = dm; M_bubble = bub;
  endtask

  // One cycle: check combinational outputs, clock, then check the M register and cc
  task step;
    #2;
    model_comb;
    check("e_valE", e_valE, x_valE);
    check("e_Cnd", {63'd0, e_Cnd}, {63'd0, x_cnd});
    check("e_dstE", {60'd0, e_dstE}, {60'd0, x_dstE});
    check("cc_pre", {61'd0, cc}, {61'd0, m_cc});
    if (M_bubble) begin
      x_stat = 4'b1000; x_icode = 4'h1; x_cndr = 1'b0; x_valA = 64'd0;
      x_dstEr = 4'hF; x_dstMr = 4'hF; exp_q.push_back(64'd0);
    end else begin
      x_stat = E_stat; x_icode = E_icode; x_cndr = x_cnd; x_valA = E_valA;
      x_dstEr = x_dstE; x_dstMr = E_dstM; exp_q.push_back(x_valE);
    end
    @(posedge clk);
    if (x_setcc) m_cc = x_cc_new;
    #1;
    check("M_valE", M_valE, exp_q.pop_front());
    check("M_stat", {60'd0, M_stat}, {60'd0, x_stat});
    check("M_icode", {60'd0, M_icode}, {60'd0, x_icode});
    check("M_Cnd", {63'd0, M_Cnd}, {63'd0, x_cndr});
    check("M_valA", M_valA, x_valA);
    check("M_dstE", {60'd0, M_dstE}, {60'd0, x_dstEr});
    check("M_dstM", {60'd0, M_dstM}, {60'd0, x_dstMr});
    check("cc_post", {61'd0, cc}, {61'd0, m_cc});
  endtask

  task automatic check_reset_image(input string tag);
    check({tag, "_icode"}, {60'd0, M_icode}, 64'h1);
    check({tag, "_dstE"}, {60'd0, M_dstE}, 64'hF);
    check({tag, "_dstM"}, {60'd0, M_dstM}, 64'hF);
    check({tag, "_stat"}, {60'd0, M_stat}, 64'h8);
    check({tag, "_valE"}, M_valE, 64'd0);
    check({tag, "_valA"}, M_valA, 64'd0);
    check({tag, "_Cnd"}, {63'd0, M_Cnd}, 64'd0);
    check({tag, "_cc"}, {61'd0, cc}, 64'h4);
  endtask

  function automatic logic [63:0] pick_val();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      4: return {60'd0, 4'($urandom_range(0, 15))};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1; m_cc = 3'b100;
    E_stat = 4'b1000; m_stat = 4'b1000; W_stat = 4'b1000;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
    repeat (2) @(posedge clk);
    #1 check_reset_image("rst_init");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Add overflowing into the sign bit
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2, 4'hF, 1'b0);
    #1 check("t2_valE", e_valE, 64'h8000_0000_0000_0000);
    step;
    check("t2_cc", {61'd0, cc}, 64'h3);

    // subq equal operands, then cmovle taken and cmovne not taken
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, 4'hF, 1'b0);
    step;
    check("t3_cc", {61'd0, cc}, 64'h4);
    drive(4'h2, 4'h1, 64'd11, 64'd0, 64'd0, 4'h6, 4'hF, 1'b0);
    #1 check("t3_le_cnd", {63'd0, e_Cnd}, 64'd1);
    check("t3_le_dst", {60'd0, e_dstE}, 64'h6);
    step;
    drive(4'h2, 4'h4, 64'd11, 64'd0, 64'd0, 4'h6, 4'hF, 1'b0);
    #1 check("t3_ne_cnd", {63'd0, e_Cnd}, 64'd0);
    check("t3_ne_dst", {60'd0, e_dstE}, 64'hF);
    step;

    // xor to zero with an address exception downstream: flags frozen
    m_stat = 4'b0010;
    drive(4'h6, 4'h3, 64'd3, 64'd3, 64'd0, 4'h1, 4'hF, 1'b0);
    step;
    check("t4_cc", {61'd0, cc}, 64'h4);
    check("t4_valE", M_valE, 64'd0);
    m_stat = 4'b1000;

    // Stack pointer arithmetic and immediate move
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'hF, 1'b0);
    step;
    check("t5_push", M_valE, 64'hF8);
    drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4, 4'h1, 1'b0);
    step;
    check("t5_pop", M_valE, 64'h108);
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'd7, 4'h2, 4'hF, 1'b0);
    step;
    check("t5_irmov", M_valE, 64'd7);

    // Bubble, then the same instruction flows through
    drive(4'h3, 4'h0, 64'd0, 64'd0, 64'd9, 4'h3, 4'hF, 1'b1);
    step;
    check("t6_bub_icode", {60'd0, M_icode}, 64'h1);
    check("t6_bub_dstE", {60'd0, M_dstE}, 64'hF);
    M_bubble = 1'b0;
    step;
    check("t6_valE", M_valE, 64'd9);

    // Bubble coinciding with a flag-setting OPq: flags still update
    drive(4'h6, 4'h1, 64'd1, 64'd0, 64'd0, 4'h2, 4'hF, 1'b1);
    step;
    check("bub_cc", {61'd0, cc}, 64'h2);

    // Randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      E_stat = 4'b1000 >> $urandom_range(0, 3);
      m_stat = ($urandom_range(0, 3) == 0) ? (4'b1000 >> $urandom_range(0, 3)) : 4'b1000;
      W_stat = ($urandom_range(0, 3) == 0) ? (4'b1000 >> $urandom_range(0, 3)) : 4'b1000;
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), pick_val(), pick_val(),
            pick_val(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 7) == 0));
      step;
    end

    // Reset asserted mid-cycle takes effect without a clock edge
    E_stat = 4'b1000; m_stat = 4'b1000; W_stat = 4'b1000;
    drive(4'h6, 4'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 4'h5, 4'h7, 1'b0);
    step;
    drive(4'h5, 4'h0, 64'd3, 64'd4, 64'd5, 4'h5, 4'h7, 1'b0);
    #2 rst = 1'b1;
    m_cc = 3'b100;
    #1 check_reset_image("rst_mid");
    @(posedge clk); #1;
    check_reset_image("rst_hold");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    drive(4'h6, 4'h2, 64'hF0, 64'h0F, 64'd0, 4'h1, 4'hF, 1'b0);
    step;
    check("after_rst_cc", {61'd0, cc}, 64'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
